// File: rtl/bcd2bin.sv
// bcd2bin: serial BCD-to-binary converter (reverse double-dabble).
// A packed BCD word is loaded on start. Each following clock shifts it right
// by one bit and corrects every digit that reached 8 or more by subtracting 3.
// The bit shifted out is the next binary result bit, LSB first.
// Optional feature macro: BCD2BIN_DIGIT_CHECK_EN. When it is defined, a load
// containing a digit above 9 is rejected and digitErr is raised.
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcdIn,
  output logic                  busy,
  output logic                  binStream,
  output logic                  binValid,
  output logic                  done,
  output logic [BIN_W-1:0]      bin,
  output logic                  digitErr
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_bcd;
  logic [W-1:0]       r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_stream;
  logic               r_valid;
  logic               r_done;
  logic [BIN_W-1:0]   r_bin_out;

  logic [W-1:0]       w_shift;
  logic [W-1:0]       w_bcd_next;
  logic [W-1:0]       w_bin_next;
  logic               w_bit;
  logic               w_last;
  logic               w_unused_bin;

  // Digit correction after the right shift: any digit >= 8 loses 3, per digit,
  // with no borrow propagating into the neighbouring digit.
  function automatic logic [W-1:0] f_adjust(input logic [W-1:0] v);
    logic [W-1:0] res;
    logic [3:0]   d;
    res = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (d >= 4'd8) begin
        res[4*i +: 4] = d - 4'd3;
      end else begin
        res[4*i +: 4] = d;
      end
    end
    return res;
  endfunction

  assign w_bit      = r_bcd[0];
  assign w_shift    = {1'b0, r_bcd[W-1:1]};
  assign w_bcd_next = f_adjust(w_shift);
  assign w_bin_next = {w_bit, r_bin[W-1:1]};
  assign w_last     = (r_cnt == CNT_W'(W - 1));

  // The LSB of the partial result is always shifted out and never read again.
  assign w_unused_bin = r_bin[0];

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic r_derr;
  logic w_bad;

  // True when any packed digit holds a non-decimal code (10..15).
  function automatic logic f_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign w_bad    = f_bad_digit(bcdIn);
  assign digitErr = r_derr;
`else
  assign digitErr = 1'b0;
`endif

  // Control FSM and datapath: load on start, one reverse double-dabble step per CONV edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_stream  <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_bin_out <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      r_derr    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done   <= 1'b0;
          r_valid  <= 1'b0;
          r_stream <= 1'b0;
          if (start) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (w_bad) begin
              // Rejected load: report completion with a zero result, no conversion.
              r_derr    <= 1'b1;
              r_done    <= 1'b1;
              r_bin_out <= '0;
            end else begin
              r_derr  <= 1'b0;
              r_bcd   <= bcdIn;
              r_bin   <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_CONV;
            end
`else
            r_bcd   <= bcdIn;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CONV: begin
          r_bcd    <= w_bcd_next;
          r_bin    <= w_bin_next;
          r_stream <= w_bit;
          r_valid  <= 1'b1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bin_out <= w_bin_next[BIN_W-1:0];
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign binStream = r_stream;
  assign binValid  = r_valid;
  assign done      = r_done;
  assign bin       = r_bin_out;

endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin: directed, scoreboard-based bench for bcd2bin (DIGITS=4, BIN_W=14).
// Expected stream bits and parallel results come from a decimal model of the
// BCD input and are queued at stimulus time, then consumed as the DUT emits them.
module tb_bcd2bin;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bcdIn;
  logic        busy;
  logic        binStream;
  logic        binValid;
  logic        done;
  logic [13:0] bin;
  logic        digitErr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int done_cyc = 0;
  bit saw_done = 1'b0;
  bit          q_stream[$];
  logic [13:0] q_bin[$];

  bcd2bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bcdIn     (bcdIn),
    .busy      (busy),
    .binStream (binStream),
    .binValid  (binValid),
    .done      (done),
    .bin       (bin),
    .digitErr  (digitErr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed 4-digit BCD word.
  function automatic logic [13:0] bcd_val(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return 14'(v);
  endfunction

  // Queue the stream bits and parallel result a valid conversion must produce.
  task automatic push_conv(input logic [15:0] b);
    logic [13:0] e;
    e = bcd_val(b);
    for (int i = 0; i < 16; i++) begin
      if (i < 14) q_stream.push_back(e[i]);
      else        q_stream.push_back(1'b0);
    end
    q_bin.push_back(e);
  endtask

  // Scoreboard consumer: runs once per sampled cycle.
  task automatic monitor();
    if (binValid === 1'b1) begin
      check("stream_pending", 32'(q_stream.size() > 0), 32'd1);
      if (q_stream.size() > 0) check("stream_bit", 32'(binStream), 32'(q_stream.pop_front()));
    end
    if (done === 1'b1) begin
      n_done++;
      saw_done = 1'b1;
      done_cyc = cyc;
      check("bin_pending", 32'(q_bin.size() > 0), 32'd1);
      if (q_bin.size() > 0) check("bin", 32'(bin), 32'(q_bin.pop_front()));
    end
  endtask

  // One clock: outputs sampled 1 unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_done(input string tag);
    saw_done = 1'b0;
    for (int k = 0; k < 40 && !saw_done; k++) tick();
    check({tag, "_done_seen"}, 32'(saw_done), 32'd1);
  endtask

  // Single conversion with cycle-accurate busy/done/latency checks.
  task automatic conv_basic(input logic [15:0] b, input string tag);
    int t0;
    bcdIn = b;
    start = 1'b1;
    push_conv(b);
    tick();                       // E0
    start = 1'b0;
    t0 = cyc;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_valid_e0"}, 32'(binValid), 32'd0);
    for (int k = 1; k < 16; k++) tick();   // E1..E15
    check({tag, "_busy_e15"}, 32'(busy), 32'd1);
    check({tag, "_done_e15"}, 32'(done), 32'd0);
    tick();                       // E16
    check({tag, "_latency"}, 32'(cyc - t0), 32'd16);
    check({tag, "_done_e16"}, 32'(done), 32'd1);
    check({tag, "_busy_e16"}, 32'(busy), 32'd0);
    check({tag, "_valid_e16"}, 32'(binValid), 32'd1);
    check({tag, "_digiterr"}, 32'(digitErr), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_valid_after"}, 32'(binValid), 32'd0);
    check({tag, "_bin_held"}, 32'(bin), 32'(bcd_val(b)));
    check({tag, "_stream_drained"}, 32'(q_stream.size()), 32'd0);
  endtask

  initial begin
    int n0;
    int d1;
    reset = 1'b1;
    start = 1'b0;
    bcdIn = 16'h0000;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stream", 32'(binStream), 32'd0);
    check("rst_valid", 32'(binValid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin", 32'(bin), 32'd0);
    check("rst_digiterr", 32'(digitErr), 32'd0);
    reset = 1'b0;
    tick();

    conv_basic(16'h1234, "c1234");
    conv_basic(16'h9999, "c9999");
    conv_basic(16'h0000, "c0000");

    // Back-to-back with start held high: second load is taken on the edge
    // after the done cycle, so done pulses are 16+1 edges apart.
    bcdIn = 16'h0010;
    start = 1'b1;
    push_conv(16'h0010);
    push_conv(16'h0007);
    tick();
    bcdIn = 16'h0007;
    wait_done("b2b1");
    d1 = done_cyc;
    tick();
    start = 1'b0;
    wait_done("b2b2");
    check("b2b_gap", 32'(done_cyc - d1), 32'd17);
    check("b2b_bin", 32'(bin), 32'd7);
    check("b2b_drained", 32'(q_stream.size() + q_bin.size()), 32'd0);

    // Start during a conversion must be ignored.
    bcdIn = 16'h0042;
    start = 1'b1;
    push_conv(16'h0042);
    tick();
    start = 1'b0;
    repeat (4) tick();
    bcdIn = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcdIn = 16'h0000;
    wait_done("ign");
    n0 = n_done;
    repeat (20) tick();
    check("ign_no_extra_done", 32'(n_done), 32'(n0));
    check("ign_bin", 32'(bin), 32'd42);
    check("ign_drained", 32'(q_stream.size() + q_bin.size()), 32'd0);

    // Reset in the middle of a conversion discards it.
    bcdIn = 16'h0567;
    start = 1'b1;
    push_conv(16'h0567);
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stream", 32'(binStream), 32'd0);
    check("mid_rst_valid", 32'(binValid), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bin", 32'(bin), 32'd0);
    q_stream.delete();
    q_bin.delete();
    n0 = n_done;
    repeat (20) tick();
    check("mid_rst_no_done", 32'(n_done), 32'(n0));
    conv_basic(16'h0001, "c0001");

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // Invalid digit: immediate done with zero result, no stream, no busy.
    bcdIn = 16'h12A4;
    start = 1'b1;
    q_bin.push_back(14'd0);
    tick();
    start = 1'b0;
    check("err_flag", 32'(digitErr), 32'd1);
    check("err_done", 32'(done), 32'd1);
    check("err_valid", 32'(binValid), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    tick();
    check("err_done_pulse", 32'(done), 32'd0);
    check("err_flag_held", 32'(digitErr), 32'd1);
    conv_basic(16'h0003, "c0003");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
